duck_round_keeper: RTL and testbench
====================================

// Module: duck_round_keeper
// PURPOSE
//   Parametrised round/ammo/score controller for the Duck Hunt game.
//   Counts shots per bird, hits and birds per round, and advances rounds or ends the game.
//   Keeps a saturating score and a high score.
//   Sits between the firing datapath (shot/hit/escape pulses) and the movement FSM,
//   which receives spawn_bird. It also drives the HEX and LED displays.
// PARAMETERS
//   SHOTS_PER_BIRD   3   shots loaded per bird (>=1)
//   BIRDS_PER_ROUND  10  birds per round (>=1)
//   HITS_TO_PASS     6   hits needed to pass a round (<=BIRDS_PER_ROUND)
//   HIT_WINDOW       4   cycles after the last shot in which a late bird_hit still counts (>=1)
//   HIT_POINTS       1   score added per hit
//   SCORE_W          8   score / high-score width
//   ROUND_W          4   round counter width
// PORTS
//   clk              in   1        system clock (CLOCK_50 domain)
//   reset            in   1        async, active-high
//   start            in   1        level or pulse; starts a game from IDLE or GAME_OVER
//   shot_fired       in   1        1-cycle pulse per trigger
//   bird_hit         in   1        1-cycle pulse: current bird hit
//   bird_escaped     in   1        1-cycle pulse: current bird left the screen
//   spawn_bird       out  1        1-cycle pulse: launch next bird
//   remaining_shots  out  clog2(SHOTS_PER_BIRD+1)   shots left for the current bird
//   bird_idx         out  clog2(BIRDS_PER_ROUND)    index of the current bird in the round
//   hits_round       out  clog2(BIRDS_PER_ROUND+1)  hits so far this round
//   score            out  SCORE_W  current score
//   high_score       out  SCORE_W  best score since reset
//   round_num        out  ROUND_W  current round, starting at 1
//   state            out  3        FSM state code, for LEDR debug
//   game_over        out  1        high while in GAME_OVER
// BEHAVIOUR
//   - Reset (async, any state): outputs 0, state=IDLE. round_num=0. high_score=0.
//   - States (code): IDLE(0) SPAWN(1) ACTIVE(2) WAIT_HIT(3) RESOLVE(4) ROUND_END(5) GAME_OVER(6).
//   - IDLE or GAME_OVER + start -> SPAWN.
//     On that edge: score=0, round_num=1, bird_idx=0, hits_round=0.
//   - SPAWN: one cycle. spawn_bird=1. remaining_shots=SHOTS_PER_BIRD. Next state is ACTIVE.
//   - ACTIVE, checked in priority order:
//     1. bird_hit -> RESOLVE(hit).
//     2. bird_escaped -> RESOLVE(miss).
//     3. shot_fired on the last shot -> WAIT_HIT, with the window counter set to HIT_WINDOW.
//   - shot_fired decrements remaining_shots in the same cycle, including when bird_hit
//     arrives in that cycle. The counter never goes below 0.
//     Shots are ignored outside ACTIVE.
//   - WAIT_HIT: the window counter decrements every cycle.
//     bird_hit -> RESOLVE(hit). bird_escaped or counter reaching 0 -> RESOLVE(miss).
//   - RESOLVE: one cycle.
//     On a hit: hits_round+1; score+HIT_POINTS, saturating at 2^SCORE_W-1.
//     Then: bird_idx==BIRDS_PER_ROUND-1 -> ROUND_END.
//     Otherwise bird_idx+1 -> SPAWN.
//   - ROUND_END: one cycle.
//     hits_round>=HITS_TO_PASS (counting the hit just resolved) -> round pass:
//     round_num+1 (saturating), bird_idx=0, hits_round=0, next state SPAWN.
//     Otherwise -> GAME_OVER.
//   - GAME_OVER entry: if score>high_score, high_score=score (registered on the entry edge).
//     game_over=1 while in this state.
//   - Latency: hit pulse to score update = 2 edges (ACTIVE->RESOLVE edge, RESOLVE edge).
//     Hit to next spawn_bird = 2 cycles.
//   - Pulses arriving in SPAWN, RESOLVE or ROUND_END are dropped. No queuing.
//   - Reset mid-game clears everything except nothing: high_score also clears to 0.
// TESTING
//   - Reset, start, 10 birds each hit on the first shot
//     -> score=10, round_num=2, hits_round=0, remaining_shots=3 after the new SPAWN.
//   - 3 shots with no hit, bird_hit 2 cycles after the 3rd shot
//     -> counted as a hit (inside HIT_WINDOW=4). At 5 cycles -> counted as a miss.
//   - shot_fired and bird_hit in the same cycle with remaining_shots=1
//     -> RESOLVE(hit), remaining_shots=0, score+1.
//   - Round with 5 hits out of 10 -> GAME_OVER, game_over=1, high_score=score.
//     Next start -> score=0, high_score kept.
//   - SCORE_W=3, 9 consecutive hits -> score holds at 7.
//     Async reset asserted during WAIT_HIT -> all outputs 0 immediately, state=IDLE.

Source files
------------

// File: rtl/duck_round_keeper.sv
// duck_round_keeper: shot / hit / round / score bookkeeping for Duck Hunt.
// Launches birds, counts shots and hits, advances rounds, ends the game.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-high
//   start            begins a game from IDLE or GAME_OVER
//   shot_fired       1-cycle trigger pulse
//   bird_hit         1-cycle pulse, current bird was hit
//   bird_escaped     1-cycle pulse, current bird left the screen
//   spawn_bird       1-cycle pulse to the movement FSM, launch a bird
//   remaining_shots  shots left for the current bird
//   bird_idx         index of the current bird within the round
//   hits_round       hits scored so far this round
//   score            saturating game score
//   high_score       best score seen since reset
//   round_num        current round, 1-based once a game is running
//   state            FSM state code for the LED debug display
//   game_over        high while the game is over
module duck_round_keeper #(
    parameter int SHOTS_PER_BIRD  = 3,
    parameter int BIRDS_PER_ROUND = 10,
    parameter int HITS_TO_PASS    = 6,
    parameter int HIT_WINDOW      = 4,
    parameter int HIT_POINTS      = 1,
    parameter int SCORE_W         = 8,
    parameter int ROUND_W         = 4,
    localparam int SHOT_W = $clog2(SHOTS_PER_BIRD + 1),
    localparam int IDX_W  = (BIRDS_PER_ROUND > 1) ?
                            $clog2(BIRDS_PER_ROUND) : 1,
    localparam int HITS_W = $clog2(BIRDS_PER_ROUND + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               shot_fired,
    input  logic               bird_hit,
    input  logic               bird_escaped,
    output logic               spawn_bird,
    output logic [SHOT_W-1:0]  remaining_shots,
    output logic [IDX_W-1:0]   bird_idx,
    output logic [HITS_W-1:0]  hits_round,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [ROUND_W-1:0] round_num,
    output logic [2:0]         state,
    output logic               game_over
);

    localparam int WIN_W = $clog2(HIT_WINDOW + 1);

    localparam logic [SHOT_W-1:0]  SHOTS_INIT = SHOT_W'(SHOTS_PER_BIRD);
    localparam logic [SHOT_W-1:0]  SHOT_ONE   = SHOT_W'(1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(BIRDS_PER_ROUND - 1);
    localparam logic [HITS_W-1:0]  HITS_ONE   = HITS_W'(1);
    localparam logic [HITS_W-1:0]  PASS_HITS  = HITS_W'(HITS_TO_PASS);
    localparam logic [WIN_W-1:0]   WIN_INIT   = WIN_W'(HIT_WINDOW);
    localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
    localparam logic [ROUND_W-1:0] ROUND_ONE  = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] ROUND_MAX  = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W:0]   PTS_EXT    = (SCORE_W + 1)'(HIT_POINTS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
        S_ACTIVE    = 3'd2,
        S_WAIT_HIT  = 3'd3,
        S_RESOLVE   = 3'd4,
        S_ROUND_END = 3'd5,
        S_GAME_OVER = 3'd6
    } state_t;

    state_t             r_state;
    logic               r_spawn;
    logic               r_game_over;
    logic               r_hit;
    logic [SHOT_W-1:0]  r_rem;
    logic [IDX_W-1:0]   r_idx;
    logic [HITS_W-1:0]  r_hits;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high;
    logic [ROUND_W-1:0] r_round;
    logic [WIN_W-1:0]   r_win;

    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_next;
    logic               w_round_pass;
    logic               w_last_bird;

    // One extra bit catches the carry so the score sticks at all-ones.
    always_comb begin
        w_score_sum  = {1'b0, r_score} + PTS_EXT;
        w_score_next = w_score_sum[SCORE_W] ? SCORE_MAX
                                            : w_score_sum[SCORE_W-1:0];
        w_round_pass = (r_hits >= PASS_HITS);
        w_last_bird  = (r_idx == LAST_IDX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_spawn     <= 1'b0;
            r_game_over <= 1'b0;
            r_hit       <= 1'b0;
            r_rem       <= '0;
            r_idx       <= '0;
            r_hits      <= '0;
            r_score     <= '0;
            r_high      <= '0;
            r_round     <= '0;
            r_win       <= '0;
        end else begin
            // spawn_bird is only high for the single SPAWN cycle.
            r_spawn <= 1'b0;
            case (r_state)
                S_IDLE, S_GAME_OVER: begin
                    if (start) begin
                        r_state     <= S_SPAWN;
                        r_spawn     <= 1'b1;
                        r_rem       <= SHOTS_INIT;
                        r_game_over <= 1'b0;
                        r_score     <= '0;
                        r_round     <= ROUND_ONE;
                        r_idx       <= '0;
                        r_hits      <= '0;
                    end
                end

                S_SPAWN: begin
                    r_state <= S_ACTIVE;
                end

                S_ACTIVE: begin
                    // The shot is spent even when the hit lands in
                    // the same cycle.
                    if (shot_fired && r_rem != '0) begin
                        r_rem <= r_rem - SHOT_ONE;
                    end
                    if (bird_hit) begin
                        r_state <= S_RESOLVE;
                        r_hit   <= 1'b1;
                    end else if (bird_escaped) begin
                        r_state <= S_RESOLVE;
                        r_hit   <= 1'b0;
                    end else if (shot_fired && r_rem == SHOT_ONE) begin
                        r_state <= S_WAIT_HIT;
                        r_win   <= WIN_INIT;
                    end
                end

                S_WAIT_HIT: begin
                    // Last shot is out; a late hit report still counts
                    // until the window runs dry.
                    r_win <= r_win - WIN_ONE;
                    if (bird_hit) begin
                        r_state <= S_RESOLVE;
                        r_hit   <= 1'b1;
                    end else if (bird_escaped || r_win == WIN_ONE) begin
                        r_state <= S_RESOLVE;
                        r_hit   <= 1'b0;
                    end
                end

                S_RESOLVE: begin
                    if (r_hit) begin
                        r_hits  <= r_hits + HITS_ONE;
                        r_score <= w_score_next;
                    end
                    if (w_last_bird) begin
                        r_state <= S_ROUND_END;
                    end else begin
                        r_idx   <= r_idx + IDX_ONE;
                        r_state <= S_SPAWN;
                        r_spawn <= 1'b1;
                        r_rem   <= SHOTS_INIT;
                    end
                end

                S_ROUND_END: begin
                    // r_hits already includes the hit resolved last cycle.
                    if (w_round_pass) begin
                        if (r_round != ROUND_MAX) begin
                            r_round <= r_round + ROUND_ONE;
                        end
                        r_idx   <= '0;
                        r_hits  <= '0;
                        r_state <= S_SPAWN;
                        r_spawn <= 1'b1;
                        r_rem   <= SHOTS_INIT;
                    end else begin
                        r_state     <= S_GAME_OVER;
                        r_game_over <= 1'b1;
                        if (r_score > r_high) begin
                            r_high <= r_score;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign spawn_bird      = r_spawn;
    assign remaining_shots = r_rem;
    assign bird_idx        = r_idx;
    assign hits_round      = r_hits;
    assign score           = r_score;
    assign high_score      = r_high;
    assign round_num       = r_round;
    assign state           = r_state;
    assign game_over       = r_game_over;

endmodule

// File: tb/tb_duck_round_keeper.sv
// tb_duck_round_keeper: scoreboard bench for duck_round_keeper.
// Drives bird scenarios, predicts each spawn / game-over snapshot.
module tb_duck_round_keeper;

    localparam int NB   = 10;
    localparam int PASS = 6;
    localparam int WIN  = 4;

    localparam int K_HIT1 = 0;
    localparam int K_SAME = 1;
    localparam int K_ESC  = 2;
    localparam int K_LATE = 3;

    logic clk = 1'b0;
    logic reset, start, shot, hit, esc;

    logic       spawn_bird, game_over;
    logic [1:0] remaining_shots;
    logic [3:0] bird_idx, hits_round, round_num;
    logic [7:0] score, high_score;
    logic [2:0] state;

    logic       s3_spawn, s3_go;
    logic [1:0] s3_rem;
    logic [3:0] s3_idx, s3_hits, s3_round;
    logic [2:0] s3_score, s3_high;
    logic [2:0] s3_state;

    always #5 clk = ~clk;

    duck_round_keeper dut (
        .clk(clk), .reset(reset), .start(start),
        .shot_fired(shot), .bird_hit(hit), .bird_escaped(esc),
        .spawn_bird(spawn_bird), .remaining_shots(remaining_shots),
        .bird_idx(bird_idx), .hits_round(hits_round),
        .score(score), .high_score(high_score),
        .round_num(round_num), .state(state), .game_over(game_over)
    );

    duck_round_keeper #(.SCORE_W(3)) dut3 (
        .clk(clk), .reset(reset), .start(start),
        .shot_fired(shot), .bird_hit(hit), .bird_escaped(esc),
        .spawn_bird(s3_spawn), .remaining_shots(s3_rem),
        .bird_idx(s3_idx), .hits_round(s3_hits),
        .score(s3_score), .high_score(s3_high),
        .round_num(s3_round), .state(s3_state), .game_over(s3_go)
    );

    typedef struct {
        bit go;
        int score, high, hits, idx, round, score3, high3;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int m_score, m_high, m_hits, m_idx, m_round, m_s3, m_high3;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input bit go);
        exp_t e;
        e.go     = go;
        e.score  = m_score;
        e.high   = m_high;
        e.hits   = m_hits;
        e.idx    = m_idx;
        e.round  = m_round;
        e.score3 = m_s3;
        e.high3  = m_high3;
        sb.push_back(e);
    endtask

    task automatic bird_done(input bit got);
        if (got) begin
            m_hits++;
            m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
            m_s3    = (m_s3 + 1 > 7) ? 7 : m_s3 + 1;
        end
        if (m_idx == NB - 1) begin
            if (m_hits >= PASS) begin
                m_round++;
                m_idx  = 0;
                m_hits = 0;
                push(1'b0);
            end else begin
                if (m_score > m_high) m_high = m_score;
                if (m_s3 > m_high3) m_high3 = m_s3;
                push(1'b1);
            end
        end else begin
            m_idx++;
            push(1'b0);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_state"}, int'(state), 0);
        chk({p, "_score"}, int'(score), 0);
        chk({p, "_high"}, int'(high_score), 0);
        chk({p, "_round"}, int'(round_num), 0);
        chk({p, "_rem"}, int'(remaining_shots), 0);
        chk({p, "_idx"}, int'(bird_idx), 0);
        chk({p, "_hits"}, int'(hits_round), 0);
        chk({p, "_spawn"}, int'(spawn_bird), 0);
        chk({p, "_go"}, int'(game_over), 0);
        chk({p, "_high3"}, int'(s3_high), 0);
        chk({p, "_state3"}, int'(s3_state), 0);
    endtask

    task automatic wait_event();
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            if (spawn_bird || game_over) begin
                chk("sb_depth", sb.size(), 1);
                if (sb.size() == 0) return;
                e = sb.pop_front();
                chk("game_over", int'(game_over), int'(e.go));
                chk("state", int'(state), e.go ? 6 : 1);
                chk("state3", int'(s3_state), e.go ? 6 : 1);
                chk("score", int'(score), e.score);
                chk("high", int'(high_score), e.high);
                chk("hits", int'(hits_round), e.hits);
                chk("idx", int'(bird_idx), e.idx);
                chk("round", int'(round_num), e.round);
                chk("score3", int'(s3_score), e.score3);
                chk("high3", int'(s3_high), e.high3);
                if (!e.go) chk("rem_spawn", int'(remaining_shots), 3);
                return;
            end
            @(negedge clk);
        end
        chk("event_timeout", int'(spawn_bird | game_over), 1);
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_score = 0;
        m_s3    = 0;
        m_hits  = 0;
        m_idx   = 0;
        m_round = 1;
        push(1'b0);
    endtask

    // Entered on the SPAWN cycle; returns at the cycle after the last pulse.
    task automatic fly(input int kind, input int d);
        bit got;
        got = 1'b0;
        @(negedge clk);
        case (kind)
            K_HIT1: begin
                shot = 1'b1;
                @(negedge clk);
                shot = 1'b0;
                chk("rem_first", int'(remaining_shots), 2);
                hit = 1'b1;
                @(negedge clk);
                hit = 1'b0;
                got = 1'b1;
            end
            K_SAME: begin
                shot = 1'b1;
                repeat (2) @(negedge clk);
                chk("rem_one", int'(remaining_shots), 1);
                hit = 1'b1;
                @(negedge clk);
                shot = 1'b0;
                hit  = 1'b0;
                chk("same_state", int'(state), 4);
                chk("same_rem", int'(remaining_shots), 0);
                got = 1'b1;
            end
            K_ESC: begin
                esc = 1'b1;
                @(negedge clk);
                esc = 1'b0;
            end
            default: begin
                shot = 1'b1;
                repeat (3) @(negedge clk);
                shot = 1'b0;
                chk("wait_state", int'(state), 3);
                chk("wait_rem", int'(remaining_shots), 0);
                if (d > 0) begin
                    repeat (d - 1) @(negedge clk);
                    hit = 1'b1;
                    @(negedge clk);
                    hit = 1'b0;
                    got = (d <= WIN);
                end
            end
        endcase
        bird_done(got);
    endtask

    int r2_kind [NB] = '{K_LATE, K_LATE, K_SAME, K_ESC, K_LATE,
                         K_HIT1, K_HIT1, K_HIT1, K_ESC, K_ESC};
    int r2_d [NB]    = '{2, 5, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        shot  = 1'b0;
        hit   = 1'b0;
        esc   = 1'b0;
        m_high  = 0;
        m_high3 = 0;
        repeat (2) @(negedge clk);
        chk_zero("por");
        reset = 1'b0;
        @(negedge clk);

        start_game();
        wait_event();
        for (int i = 0; i < NB; i++) begin
            fly(K_HIT1, 0);
            wait_event();
        end

        for (int i = 0; i < NB; i++) begin
            fly(r2_kind[i], r2_d[i]);
            wait_event();
        end
        chk("sb_drained", sb.size(), 0);

        start_game();
        wait_event();
        fly(K_HIT1, 0);
        wait_event();

        @(negedge clk);
        shot = 1'b1;
        repeat (3) @(negedge clk);
        shot = 1'b0;
        chk("pre_reset_state", int'(state), 3);
        #1 reset = 1'b1;
        #1 chk_zero("mid");
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_state", int'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
